// File: rtl/fp_decode_seq_if.sv
// Handshake bundle for the float-code to linear decoder.
// The producer/consumer side uses the master modport and the decoder uses the slave modport.
interface fp_decode_seq_if #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int FW = 4
) ();
    logic          in_valid;
    logic          in_ready;
    logic          S;
    logic [EW-1:0] E;
    logic [FW-1:0] F;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] D;
    logic          busy;

    modport master (
        output in_valid, S, E, F, out_ready,
        input  in_ready, out_valid, D, busy
    );

    modport slave (
        input  in_valid, S, E, F, out_ready,
        output in_ready, out_valid, D, busy
    );
endinterface

// File: rtl/fp_decode_seq.sv
// Iterative float-code (S, E, F) to two's-complement linear decoder.
// The magnitude is shifted left one bit per clock, and the block handles one code at a time.
module fp_decode_seq #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int FW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_decode_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, FORM, DONE} state_t;

    state_t        state;
    logic [DW-1:0] mag;
    logic [EW-1:0] cnt;
    logic          sign;

    // The largest significand shifted by the largest exponent must stay below the sign bit.
    if (FW + (2**EW - 1) > DW - 1) begin : g_width_check
        $error("fp_decode_seq: FW + 2^EW - 1 exceeds DW - 1");
    end

    // The handshake flags decode directly from the state register, so they stay glitch-free.
    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    // NOTE: all state is updated with non-blocking assignments, so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mag           <= '0;
            cnt           <= '0;
            sign          <= 1'b0;
            bus.D         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign  <= bus.S;
                        cnt   <= bus.E;
                        mag   <= {{(DW-FW){1'b0}}, bus.F};
                        state <= (bus.E != '0) ? SHIFT : FORM;
                    end
                end
                SHIFT: begin
                    mag <= mag << 1;
                    cnt <= cnt - EW'(1);
                    if (cnt == EW'(1)) state <= FORM;
                end
                FORM: begin
                    // A zero magnitude decodes to zero regardless of sign.
                    if (mag == '0)
                        bus.D <= '0;
                    else if (sign)
                        bus.D <= ~mag + DW'(1);
                    else
                        bus.D <= mag;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_decode_seq.sv
// Directed bench for fp_decode_seq: latency, sign handling, backpressure, mid-run reset and a full code sweep.
module tb_fp_decode_seq;
    localparam int DW = 12;
    localparam int EW = 3;
    localparam int FW = 4;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    fp_decode_seq_if #(.DW(DW), .EW(EW), .FW(FW)) bus ();

    fp_decode_seq #(.DW(DW), .EW(EW), .FW(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one code, then wait for out_valid. The result and the accept-to-valid edge count are returned.
    task automatic run_code(input logic s, input logic [EW-1:0] e, input logic [FW-1:0] f,
                            output logic [DW-1:0] d, output int lat, output logic busy_seen);
        bus.S        = s;
        bus.E        = e;
        bus.F        = f;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        busy_seen    = bus.busy;
        lat          = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) check("out_valid timeout", 32'(lat), 32'(e) + 1);
        d = bus.D;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        int            lat;
        logic          bsy;

        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.S         = 1'b0;
        bus.E         = '0;
        bus.F         = '0;
        #12;
        check("reset D", 32'(bus.D), 32'h000);
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        tick();
        check("in_ready after reset", 32'(bus.in_ready), 1);

        // A code with E=0 has a result on the next edge.
        run_code(1'b0, 3'd0, 4'd9, d, lat, bsy);
        check("E0 D", 32'(d), 32'h009);
        check("E0 latency", 32'(lat), 1);
        consume();
        check("E0 in_ready back", 32'(bus.in_ready), 1);
        check("E0 out_valid dropped", 32'(bus.out_valid), 0);

        // The maximum magnitude uses the longest shift.
        run_code(1'b0, 3'd7, 4'd15, d, lat, bsy);
        check("E7 D", 32'(d), 32'h780);
        check("E7 latency", 32'(lat), 8);
        check("E7 busy", 32'(bsy), 1);
        consume();

        run_code(1'b1, 3'd3, 4'd10, d, lat, bsy);
        check("neg 80", 32'(d), 32'hFB0);
        consume();
        run_code(1'b1, 3'd5, 4'd0, d, lat, bsy);
        check("neg zero", 32'(d), 32'h000);
        consume();

        // Under backpressure, the result holds and an in_valid pulse during DONE is ignored.
        run_code(1'b0, 3'd7, 4'd15, d, lat, bsy);
        check("bp D", 32'(d), 32'h780);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 1);
            bus.S        = 1'b0;
            bus.E        = 3'd1;
            bus.F        = 4'd1;
            tick();
            check("bp hold {valid,ready,D}", {19'd0, bus.out_valid, bus.in_ready, bus.D}, {19'd0, 1'b1, 1'b0, 12'h780});
        end
        bus.in_valid = 1'b0;
        consume();
        for (int i = 0; i < 12; i++) begin
            check("bp no ghost result", {30'd0, bus.out_valid, bus.busy}, 32'd0);
            tick();
        end
        check("D retained", 32'(bus.D), 32'h780);

        // Reset during the third shift of an E=6 code aborts the conversion.
        bus.S        = 1'b0;
        bus.E        = 3'd6;
        bus.F        = 4'd5;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset {valid,busy}", {30'd0, bus.out_valid, bus.busy}, 32'd0);
        check("midreset D", 32'(bus.D), 32'h000);
        tick();
        rst_n = 1'b1;
        tick();
        run_code(1'b0, 3'd2, 4'd3, d, lat, bsy);
        check("post-reset D", 32'(d), 32'h00C);
        consume();

        // Sweep every code against D = (-1)^S * F * 2^E.
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < 8; e++) begin
                for (int f = 0; f < 16; f++) begin
                    int exp_v;
                    exp_v = f * (1 << e);
                    if (s == 1) exp_v = -exp_v;
                    run_code(s[0], e[EW-1:0], f[FW-1:0], d, lat, bsy);
                    check("sweep", {20'd0, d}, {20'd0, exp_v[DW-1:0]});
                    consume();
                end
            end
        end

        // The encoder's code for -2048 (S=1, E=7, F=15) decodes to -1920.
        run_code(1'b1, 3'd7, 4'd15, d, lat, bsy);
        check("minus 2048 round-trip", 32'(d), 32'h880);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
